// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selectors, receiver state encoding and bit helpers.
// Used by both the pixel-link transmitter and nano_uart_rx.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Data wider than 32 bits is not supported; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [31:0] data, input logic [1:0] ptype);
    logic p;
    case (ptype)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~^data;
      PARITY_NONE: p = 1'b0;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for nano_uart_rx: 2-flop synchroniser, and with UART_RX_MAJORITY_EN
// a 2-of-3 vote over the current and two previous synchronised bits.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_async,
  output logic rx_s,
  output logic rx_vote
);

  logic meta_r;
  logic sync_r;

  // Two-stage synchroniser, reset to the idle-high line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= rx_async;
      sync_r <= meta_r;
    end
  end

  assign rx_s = sync_r;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_r;

  // Two older taps so the vote at mid+1 spans mid-1, mid and mid+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], sync_r};
    end
  end

  assign rx_vote = majority3(sync_r, hist_r[0], hist_r[1]);
`else
  assign rx_vote = sync_r;
`endif

endmodule

// File: rtl/nano_uart_rx.sv
// UART receiver for the Nano-to-FPGA direction of the pixel link, valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (all timing shifts by +1 clk).
module nano_uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic [BITS_N-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              parity_error,
  output logic              frame_error,
  output logic              overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(BITS_N) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2);
`else
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_N - 1);

  logic              rx_s;
  logic              rx_smp_s;
  rx_state_t         state_r;
  logic [CNT_W-1:0]  baud_cnt_r;
  logic [IDX_W-1:0]  bit_cnt_r;
  logic [BITS_N-1:0] shift_r;
  logic              par_bad_r;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_async (uart_rx),
    .rx_s     (rx_s),
    .rx_vote  (rx_smp_s)
  );

  // Frame FSM, baud/bit counters and the holding register with its handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      baud_cnt_r   <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      par_bad_r    <= 1'b0;
      data_out     <= '0;
      valid        <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= '0;
          par_bad_r  <= 1'b0;
          if (!rx_s) begin
            state_r <= START;
          end
        end
        START: begin
          if (baud_cnt_r == START_LAST) begin
            baud_cnt_r <= '0;
            state_r    <= rx_smp_s ? IDLE : DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r <= '0;
            shift_r    <= (shift_r >> 1) | (BITS_N'(rx_smp_s) << (BITS_N - 1));
            if (bit_cnt_r == IDX_LAST) begin
              state_r <= (PARITY_TYPE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + IDX_W'(1);
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        PARITY: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r <= '0;
            par_bad_r  <= (rx_smp_s != parity_bit(32'(shift_r), 2'(PARITY_TYPE)));
            state_r    <= STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt_r == BIT_LAST) begin
            baud_cnt_r <= '0;
            if (!rx_smp_s) begin
              frame_error <= 1'b1;
              state_r     <= BREAK;
            end else if (par_bad_r) begin
              parity_error <= 1'b1;
              state_r      <= IDLE;
            end else begin
              state_r <= IDLE;
              // A word finishing on the accept cycle replaces the old one seamlessly
              if (!valid || ready) begin
                data_out <= shift_r;
                valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nano_uart_rx.md
Name: nano_uart_rx

Overview:
UART receiver for the Nano-to-FPGA direction of the pixel link. It carries command and acknowledge bytes back from the Nano. It deserialises one asynchronous serial line into BITS_N-bit words and checks parity and the stop bit. Each good word is presented on a valid/ready handshake to the command logic in the send_pixel top level. It mirrors the transmitter's framing parameters so both ends share one configuration.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); must be >= 4
BITS_N, 8, data bits per frame, LSB first
PARITY_TYPE, 0, 0 none, 1 odd, 2 even

Ports:
clk  in  1  system clock (CLOCK2_50 domain)
rst_n  in  1  asynchronous active-low reset (driven from KEY[0])
uart_rx  in  1  serial line from the Nano (a GPIO pin), idle high, asynchronous
data_out  out  BITS_N  received word; stable while valid=1
valid  out  1  word available
ready  in  1  consumer accepts the word on a cycle where valid&&ready
parity_error  out  1  one-cycle pulse: parity mismatch, word discarded
frame_error  out  1  one-cycle pulse: stop bit sampled low, word discarded
overrun  out  1  one-cycle pulse: good word lost because the holding register was full

Behaviour:
- Input synchronisation:
  - uart_rx passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic uses the synchronised bit rx_s.
- Reset values: data_out=0, valid=0, all error pulses=0, state=IDLE, counters=0.
- Reset mid-frame aborts the frame with no outputs pulsed.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rx_s==0 -> START; clear the baud counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
    - 0 -> DATA, baud counter restarts.
    - 1 -> glitch; return to IDLE with no pulse.
  - DATA: every CLKS_PER_BIT cycles sample one bit into the shift register, LSB first.
    - After BITS_N samples -> PARITY if PARITY_TYPE!=0, else STOP.
  - PARITY: sample after CLKS_PER_BIT cycles.
    - Expected bit = XOR of data bits (even), or its inverse (odd).
    - Mismatch is latched; the frame still proceeds to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample 0 -> frame_error pulse, word dropped, go to BREAK.
    - Else if parity latched bad -> parity_error pulse, word dropped, go to IDLE.
    - Else word good -> go to IDLE.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line yields exactly one frame_error.
  - Frame_error takes priority over parity_error; only one pulse per frame.
- Holding register and handshake:
  - Good word, valid==0: load data_out and set valid on the next edge.
  - Latency: valid rises 1 clk after the stop-bit sample cycle.
  - valid&&ready: valid clears next edge unless a good word completes in that same cycle. In that case the new word loads, valid stays 1, and there is no overrun.
  - Good word while valid&&!ready: keep the old data_out, drop the new word, pulse overrun.
  - data_out never changes while valid=1 and ready=0.
- Back-to-back frames: a start bit may begin the cycle after leaving STOP. No idle gap is required beyond the stop bit.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined:
  - Each start, data, parity and stop sample is a 2-of-3 majority of rx_s at the mid-point cycle and the cycles one before and one after.
  - The decision is available at the mid-point+1 cycle, so all downstream timing shifts by +1 clk.
- Undefined: single sample at the mid-point cycle.

Decomposition:
- Package uart_pkg, shared with the transmitter:
  - PARITY_NONE/ODD/EVEN localparams.
  - rx_state_t enum.
  - Function parity_bit(data, type).
- Sub-module uart_rx_sync: 2-flop synchroniser plus the optional 3-tap majority shift register.
- FSM, counters and holding register stay in nano_uart_rx.

Test Plan:
- CLKS_PER_BIT=8, 8N1, send 0xA5 with ready=1 -> valid for 1 clk with data_out=0xA5, about 10*8+3 clks after the start edge; no error pulses.
- PARITY_TYPE=2, send 0x03 with parity bit 1 (wrong) -> one parity_error pulse, valid stays 0. Resend 0x03 with parity 0 -> valid with 0x03.
- Send 0x7E with stop bit forced 0, then hold the line low for 40 clks -> exactly one frame_error pulse, no valid. After the line returns high, 0x11 is received correctly.
- Low glitch of 3 clks on the idle line -> no valid, no errors, FSM back in IDLE.
- ready=0, send 0x12 then 0x34 back-to-back -> data_out=0x12 held, one overrun pulse at the second stop. Then ready=1 -> valid drops the next clk.
- Assert rst_n=0 during the DATA bits of 0x55, release, then send 0x99 -> outputs at reset values throughout, next valid carries 0x99. Repeat with UART_RX_MAJORITY_EN defined and a 1-clk glitch at a data-bit midpoint -> still 0x99.
